fetch_queue_stage: RTL and testbench

- Parametrised instruction-fetch stage with a DEPTH-entry prefetch queue between instruction memory and decode.
- Generates the PC and requests instructions from an external instruction-memory port, which may stall.
- Buffers {pc, instr} pairs so decode stalls do not stop fetch until the queue fills.
- Redirects and flushes on a taken branch from Execute. It sits between the hazard/branch logic and the Decode stage.

---
 rtl/fetch_queue_stage.sv | 118 +++++++++++
 tb/tb_fetch_queue_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage
//   Instruction-fetch stage with a DEPTH-entry prefetch queue between the
//   instruction memory and Decode. The PC advances only when a fetched word
//   is accepted into the queue, so memory wait states and a full queue both
//   freeze the fetch address. A taken branch from Execute flushes the queue
//   and redirects the PC.
//
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   isbranchtakenE   taken-branch redirect (flush) from Execute
//   branchtargetE    redirect target (low two bits ignored)
//   stallD           Decode cannot accept the head this cycle
//   imem_addr        fetch address (= PC)
//   imem_rdata       instruction at imem_addr, valid when imem_valid=1
//   imem_valid       low = instruction-memory wait state
//   validD           queue head holds a valid instruction
//   instrD, pcD      head instruction and its PC (0 when validD=0)
//   pcplus4D         pcD + 4 (0 when validD=0)
//   occupancy        number of valid queue entries
module fetch_queue_stage #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    localparam int             OW       = $clog2(DEPTH + 1),
    localparam int             PW       = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            isbranchtakenE,
    input  logic [XLEN-1:0] branchtargetE,
    input  logic            stallD,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            imem_valid,
    output logic            validD,
    output logic [ILEN-1:0] instrD,
    output logic [XLEN-1:0] pcD,
    output logic [XLEN-1:0] pcplus4D,
    output logic [OW-1:0]   occupancy
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_queue_stage: DEPTH must be a power of two >= 2");
    end

    localparam logic [XLEN-1:0] PC_INIT = {RESET_PC[XLEN-1:2], 2'b00};

    logic [XLEN-1:0] pc_q, pc_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [OW-1:0]   occ_q, occ_d;

    // Queue storage needs no reset: every read is qualified by occupancy.
    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [ILEN-1:0] instr_mem_q [DEPTH];

    logic flush, pop, push, full;

    assign flush = isbranchtakenE;
    assign full  = (occ_q == OW'(DEPTH));
    assign pop   = validD & ~stallD & ~flush;
    // A full queue still accepts a word when the head leaves the same cycle.
    assign push  = imem_valid & ~flush & (~full | pop);

    always_comb begin
        pc_d   = pc_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (flush) begin
            pc_d   = {branchtargetE[XLEN-1:2], 2'b00};
            wptr_d = '0;
            rptr_d = '0;
            occ_d  = '0;
        end else begin
            if (push) begin
                pc_d   = pc_q + XLEN'(4);
                wptr_d = wptr_q + PW'(1);
            end
            if (pop) rptr_d = rptr_q + PW'(1);
            if (push && !pop) occ_d = occ_q + OW'(1);
            else if (pop && !push) occ_d = occ_q - OW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= PC_INIT;
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            pc_q   <= pc_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wptr_q]    <= pc_q;
            instr_mem_q[wptr_q] <= imem_rdata;
        end
    end

    // Head outputs come only from registered storage and are forced to zero
    // when the queue is empty, so an empty queue presents a NOP. Because
    // occupancy resets asynchronously, the outputs clear as soon as rst rises.
    assign validD    = (occ_q != '0);
    assign instrD    = validD ? instr_mem_q[rptr_q] : '0;
    assign pcD       = validD ? pc_mem_q[rptr_q] : '0;
    assign pcplus4D  = validD ? pc_mem_q[rptr_q] + XLEN'(4) : '0;
    assign occupancy = occ_q;
    assign imem_addr = pc_q;

endmodule

// File: tb/tb_fetch_queue_stage.sv
module tb_fetch_queue_stage;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] MEMBASE = 32'h1000_0000;
    localparam logic [31:0] ALT_PC  = 32'hBFC0_0003;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        isbranchtakenE = 1'b0;
    logic [31:0] branchtargetE = '0;
    logic        stallD = 1'b0;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_addr, imem_rdata, instrD, pcD, pcplus4D;
    logic        validD;
    logic [2:0]  occupancy;

    logic [31:0] imem_addr2, imem_rdata2, instrD2, pcD2, pcplus4D2;
    logic        validD2;
    logic [2:0]  occupancy2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Instruction memory: word at addr is MEMBASE + addr, always same-cycle.
    assign imem_rdata  = MEMBASE + imem_addr;
    assign imem_rdata2 = MEMBASE + imem_addr2;

    fetch_queue_stage #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .isbranchtakenE(isbranchtakenE), .branchtargetE(branchtargetE),
        .stallD(stallD), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .validD(validD), .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D), .occupancy(occupancy));

    fetch_queue_stage #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(ALT_PC)) dut2 (
        .clk(clk), .rst(rst), .isbranchtakenE(isbranchtakenE), .branchtargetE(branchtargetE),
        .stallD(stallD), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2), .imem_valid(imem_valid),
        .validD(validD2), .instrD(instrD2), .pcD(pcD2), .pcplus4D(pcplus4D2), .occupancy(occupancy2));

    // Reference model: a FIFO of {pc, instr} pairs plus a fetch PC.
    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t        mq[$];
    logic [31:0] mpc = 32'h0;

    wire [131:0] obsv = {validD, instrD, pcD, pcplus4D, occupancy, imem_addr};

    function automatic logic [131:0] expv();
        ent_t h = '0;
        logic v = (mq.size() > 0);
        if (v) h = mq[0];
        return {v, h.instr, h.pc, v ? h.pc + 32'd4 : 32'd0, 3'(mq.size()), mpc};
    endfunction

    // Advance one clock; the model applies the same cycle's rules to its queue.
    task automatic tick();
        logic fl, pp, ps;
        fl = isbranchtakenE;
        pp = (mq.size() > 0) && !stallD && !fl;
        ps = imem_valid && !fl && ((mq.size() < DEPTH) || pp);
        @(posedge clk);
        if (fl) begin
            mq.delete();
            mpc = branchtargetE & ~32'h3;
        end else begin
            if (pp) void'(mq.pop_front());
            if (ps) begin
                mq.push_back('{pc: mpc, instr: MEMBASE + mpc});
                mpc = mpc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; isbranchtakenE = 0; stallD = 0; imem_valid = 0; branchtargetE = '0;
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        mpc = 32'h0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (obsv !== 132'h0) begin
            fails++; $display("FAIL reset_state got %h want 0", obsv);
        end
        tests++;
        if (imem_addr2 !== 32'hBFC0_0000 || validD2 !== 1'b0) begin
            fails++; $display("FAIL reset_pc_alt got addr %h v %b want bfc00000 v 0", imem_addr2, validD2);
        end
        imem_valid = 1;
        tick();
        tests++;
        if (pcD2 !== 32'hBFC0_0000 || instrD2 !== 32'hCFC0_0000 || imem_addr2 !== 32'hBFC0_0004) begin
            fails++; $display("FAIL alt_first_fetch got pc %h instr %h addr %h want bfc00000 cfc00000 bfc00004",
                              pcD2, instrD2, imem_addr2);
        end
    endtask

    task automatic test_stream();
        do_reset();
        imem_valid = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if (obsv !== expv() || pcD !== 32'(4 * i) || occupancy !== 3'd1) begin
                fails++; $display("FAIL stream[%0d] got %h want %h pcD want %h", i, obsv, expv(), 4 * i);
            end
        end
    endtask

    task automatic test_stall_full();
        do_reset();
        imem_valid = 1; stallD = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if (obsv !== expv()) begin
                fails++; $display("FAIL stall[%0d] got %h want %h", i, obsv, expv());
            end
        end
        tests++;
        if (occupancy !== 3'd4 || imem_addr !== 32'h10 || pcD !== 32'h0) begin
            fails++; $display("FAIL stall_frozen got occ %0d addr %h pc %h want 4 10 0", occupancy, imem_addr, pcD);
        end
        // One pop from full: push goes through in the same cycle.
        stallD = 0;
        tick();
        tests++;
        if (occupancy !== 3'd4 || imem_addr !== 32'h14 || pcD !== 32'h4 || obsv !== expv()) begin
            fails++; $display("FAIL full_pop_push got occ %0d addr %h pc %h want 4 14 4", occupancy, imem_addr, pcD);
        end
        imem_valid = 0;
        for (int i = 2; i <= 5; i++) begin
            tick();
            tests++;
            if (obsv !== expv() || (i <= 4 && pcD !== 32'(4 * i))) begin
                fails++; $display("FAIL drain[%0d] got %h want %h", i, obsv, expv());
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        imem_valid = 1; stallD = 1;
        repeat (3) tick();
        tests++;
        if (occupancy !== 3'd3) begin
            fails++; $display("FAIL branch_setup got occ %0d want 3", occupancy);
        end
        isbranchtakenE = 1; branchtargetE = 32'h0000_0203;
        tick();
        tests++;
        if (validD !== 1'b0 || occupancy !== 3'd0 || imem_addr !== 32'h200 || obsv !== expv()) begin
            fails++; $display("FAIL branch_flush got v %b occ %0d addr %h want 0 0 200", validD, occupancy, imem_addr);
        end
        isbranchtakenE = 0; stallD = 0;
        tick();
        tests++;
        if (pcD !== 32'h200 || pcplus4D !== 32'h204 || instrD !== 32'h1000_0200) begin
            fails++; $display("FAIL branch_target got pc %h p4 %h instr %h want 200 204 10000200", pcD, pcplus4D, instrD);
        end
        // Back-to-back flushes: the later target wins.
        isbranchtakenE = 1; branchtargetE = 32'h0000_1000;
        tick();
        branchtargetE = 32'h0000_2002;
        tick();
        isbranchtakenE = 0;
        tests++;
        if (imem_addr !== 32'h2000 || validD !== 1'b0) begin
            fails++; $display("FAIL b2b_flush got addr %h v %b want 2000 0", imem_addr, validD);
        end
        // Wrap of the PC past the top of the address space.
        isbranchtakenE = 1; branchtargetE = 32'hFFFF_FFFE;
        tick();
        isbranchtakenE = 0;
        tick();
        tests++;
        if (pcD !== 32'hFFFF_FFFC || pcplus4D !== 32'h0 || imem_addr !== 32'h0 || obsv !== expv()) begin
            fails++; $display("FAIL pc_wrap got pc %h p4 %h addr %h want fffffffc 0 0", pcD, pcplus4D, imem_addr);
        end
    endtask

    task automatic test_wait_states();
        logic [3:0] pat;
        logic [3:0] vexp;
        pat  = 4'b1001;   // applied LSB first: 1,0,0,1
        vexp = 4'b1001;   // validD after each cycle: bubble during the waits
        do_reset();
        for (int i = 0; i < 4; i++) begin
            imem_valid = pat[i];
            tick();
            tests++;
            if (obsv !== expv() || validD !== vexp[i]) begin
                fails++; $display("FAIL wait[%0d] got %h v %b want %h", i, obsv, validD, expv());
            end
        end
        tests++;
        if (imem_addr !== 32'h8 || pcD !== 32'h4) begin
            fails++; $display("FAIL wait_pc got addr %h pc %h want 8 4", imem_addr, pcD);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        imem_valid = 1; stallD = 1;
        repeat (5) tick();
        isbranchtakenE = 1; branchtargetE = 32'h40;
        #2 rst = 1'b1;
        #1;
        tests++;
        if (obsv !== 132'h0 || imem_addr2 !== 32'hBFC0_0000) begin
            fails++; $display("FAIL async_reset got %h alt addr %h want 0 bfc00000", obsv, imem_addr2);
        end
        @(negedge clk);
        rst = 1'b0; isbranchtakenE = 0; stallD = 0;
        mq.delete();
        mpc = 32'h0;
        tick();
        tests++;
        if (pcD !== 32'h0 || obsv !== expv()) begin
            fails++; $display("FAIL after_async_reset got %h want %h", obsv, expv());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            imem_valid     = ($urandom_range(3) != 0);
            stallD         = ($urandom_range(9) < 4);
            isbranchtakenE = ($urandom_range(19) == 0);
            branchtargetE  = $urandom;
            tick();
            tests++;
            if (obsv !== expv()) begin
                fails++; $display("FAIL random[%0d] got %h want %h", i, obsv, expv());
            end
        end
        isbranchtakenE = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_full();
        test_branch();
        test_wait_states();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
